// File: rtl/button_pkg.sv
// Shared encodings for the front-panel button gesture decoder.
// State codes and gesture pulse ordering used by the decoder and the fan FSMs.
package button_pkg;

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_PRESSED        = 3'd1,
        ST_WAIT_SECOND    = 3'd2,
        ST_SECOND_PRESSED = 3'd3,
        ST_LONG_HELD      = 3'd4
    } btn_state_e;

    // Bit position of each gesture in the pulse vector.
    typedef enum logic [1:0] {
        G_SHORT  = 2'd0,
        G_DOUBLE = 2'd1,
        G_LONG   = 2'd2,
        G_REPEAT = 2'd3
    } gesture_e;

    localparam int unsigned NUM_GESTURES = 4;

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts 0..TICK_DIV-1 and flags the last count.
// Ports: clk, reset_p (sync, active-high), clr (sync restart), tick (1-cycle).
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 100_000
) (
    input  logic clk,
    input  logic reset_p,
    input  logic clr,
    output logic tick
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    assign tick = (cnt_q == PW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies debounced press/release pulses into click, double click,
// long press and auto-repeat gestures.
// Ports: clk, reset_p (sync, active-high), btn_pe/btn_ne (1-cycle edges in),
// short_click/double_click/long_press/repeat_pulse (1-cycle out), held (level).
module button_event_decoder
    import button_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100_000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DCLICK_MS = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic clk,
    input  logic reset_p,
    input  logic btn_pe,
    input  logic btn_ne,
    output logic short_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int unsigned MAX_MS = max3(LONG_MS, DCLICK_MS, REPEAT_MS);
    localparam int unsigned MW     = $clog2(MAX_MS + 1);

    btn_state_e              state_q, state_d;
    logic [MW-1:0]           ms_q, ms_d;
    logic [NUM_GESTURES-1:0] pulse_q, pulse_d;
    logic                    held_q, held_d;

    logic tick;
    logic clr;
    logic restart;
    logic pe_ok;
    logic ne_ok;
    logic to_long;
    logic to_dclick;
    logic to_repeat;

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset_p(reset_p),
        .clr    (clr),
        .tick   (tick)
    );

    // Simultaneous edges are a glitch and cancel each other.
    assign pe_ok = btn_pe & ~btn_ne;
    assign ne_ok = btn_ne & ~btn_pe;

    // Timeout X fires on the tick that would take the counter to X,
    // so the counter never has to hold X itself.
    assign to_long   = tick && (ms_q == MW'(LONG_MS - 1));
    assign to_dclick = tick && (ms_q == MW'(DCLICK_MS - 1));
    assign to_repeat = tick && (ms_q == MW'(REPEAT_MS - 1));

    always_comb begin
        state_d = state_q;
        pulse_d = '0;
        restart = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pe_ok) state_d = ST_PRESSED;
            end
            ST_PRESSED: begin
                if (ne_ok) begin
                    state_d = ST_WAIT_SECOND;
                end else if (to_long) begin
                    pulse_d[G_LONG] = 1'b1;
                    state_d         = ST_LONG_HELD;
                end
            end
            ST_WAIT_SECOND: begin
                // Timeout wins, but a coincident press still starts a gesture.
                if (to_dclick) begin
                    pulse_d[G_SHORT] = 1'b1;
                    state_d          = pe_ok ? ST_PRESSED : ST_IDLE;
                end else if (pe_ok) begin
                    state_d = ST_SECOND_PRESSED;
                end
            end
            ST_SECOND_PRESSED: begin
                if (ne_ok) begin
                    pulse_d[G_DOUBLE] = 1'b1;
                    state_d           = ST_IDLE;
                end else if (to_long) begin
                    pulse_d[G_LONG] = 1'b1;
                    state_d         = ST_LONG_HELD;
                end
            end
            ST_LONG_HELD: begin
                if (ne_ok) begin
                    state_d = ST_IDLE;
                end else if (to_repeat) begin
                    pulse_d[G_REPEAT] = 1'b1;
                    restart           = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // IDLE never times out, so its counters are held at zero.
    assign clr = (state_d != state_q) || restart || (state_q == ST_IDLE);

    always_comb begin
        ms_d = ms_q;
        if (clr) begin
            ms_d = '0;
        end else if (tick) begin
            ms_d = ms_q + 1'b1;
        end
    end

    always_comb begin
        held_d = (state_d == ST_PRESSED) ||
                 (state_d == ST_SECOND_PRESSED) ||
                 (state_d == ST_LONG_HELD);
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q <= ST_IDLE;
            ms_q    <= '0;
            pulse_q <= '0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    assign short_click  = pulse_q[G_SHORT];
    assign double_click = pulse_q[G_DOUBLE];
    assign long_press   = pulse_q[G_LONG];
    assign repeat_pulse = pulse_q[G_REPEAT];
    assign held         = held_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder with a 4-cycle ms tick.
// Expected gesture pulses are queued per scenario and matched as they appear.
module tb_button_event_decoder;

    localparam int K_SHORT  = 1;
    localparam int K_DOUBLE = 2;
    localparam int K_LONG   = 4;
    localparam int K_REP    = 8;

    typedef struct {
        int cyc;
        int kind;
    } ev_t;

    logic clk = 1'b0;
    logic reset_p = 1'b1;
    logic btn_pe = 1'b0;
    logic btn_ne = 1'b0;
    logic short_click;
    logic double_click;
    logic long_press;
    logic repeat_pulse;
    logic held;

    ev_t sb[$];
    int  n_chk  = 0;
    int  n_pass = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .TICK_DIV (4),
        .LONG_MS  (10),
        .DCLICK_MS(5),
        .REPEAT_MS(3)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .btn_pe      (btn_pe),
        .btn_ne      (btn_ne),
        .short_click (short_click),
        .double_click(double_click),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse),
        .held        (held)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int pulses();
        return {28'd0, repeat_pulse, long_press, double_click, short_click};
    endfunction

    task automatic expect_ev(input int c, input int k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        sb.push_back(e);
    endtask

    task automatic run(
        input string nm,
        input int pe0, input int pe1,
        input int ne0, input int ne1,
        input int rst,
        input int lo0, input int hi0,
        input int lo1, input int hi1,
        input int len
    );
        int  v;
        int  hexp;
        int  held_bad;
        ev_t e;
        @(posedge clk); #1;
        reset_p = 1'b1;
        btn_pe  = 1'b0;
        btn_ne  = 1'b0;
        @(posedge clk); #1;
        reset_p = 1'b0;
        @(negedge clk);
        check({nm, "/rst_pulses"}, pulses(), 0);
        check({nm, "/rst_held"}, int'(held), 0);
        held_bad = 0;
        @(posedge clk); #1;
        for (int k = 0; k < len; k++) begin
            btn_pe  = (k == pe0) || (k == pe1);
            btn_ne  = (k == ne0) || (k == ne1);
            reset_p = (k == rst);
            @(negedge clk);
            v = pulses();
            if (v != 0) begin
                if (sb.size() == 0) begin
                    check($sformatf("%s/unexpected@%0d", nm, k), v, 0);
                end else begin
                    e = sb.pop_front();
                    check({nm, "/cycle"}, k, e.cyc);
                    check({nm, "/kind"}, v, e.kind);
                end
            end
            hexp = ((k >= lo0 && k <= hi0) || (k >= lo1 && k <= hi1)) ? 1 : 0;
            if (int'(held) != hexp && held_bad == 0) begin
                held_bad = 1;
                check($sformatf("%s/held@%0d", nm, k), int'(held), hexp);
            end
            @(posedge clk); #1;
        end
        btn_pe  = 1'b0;
        btn_ne  = 1'b0;
        reset_p = 1'b0;
        check({nm, "/held_ok"}, held_bad, 0);
        check({nm, "/leftover"}, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        expect_ev(29, K_SHORT);
        run("short", 0, -1, 8, -1, -1, 1, 8, -1, -1, 45);

        expect_ev(41, K_LONG);
        expect_ev(53, K_REP);
        expect_ev(65, K_REP);
        run("long", 0, -1, 70, -1, -1, 1, 70, -1, -1, 90);

        expect_ev(21, K_DOUBLE);
        run("double", 0, 15, 8, 20, -1, 1, 8, 16, 20, 50);

        expect_ev(29, K_SHORT);
        expect_ev(56, K_SHORT);
        run("win28", 0, 28, 8, 35, -1, 1, 8, 29, 35, 70);

        expect_ev(29, K_SHORT);
        expect_ev(57, K_SHORT);
        run("win29", 0, 29, 8, 36, -1, 1, 8, 30, 36, 70);

        run("glitch", 0, -1, 0, -1, -1, -1, -1, -1, -1, 20);

        run("reset", 2, -1, 35, -1, 30, 3, 30, -1, -1, 80);

        expect_ev(56, K_LONG);
        expect_ev(68, K_REP);
        run("second_long", 0, 15, 8, -1, -1, 1, 8, 16, 1000, 75);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Consumes the one-cycle press/release pulses produced by the button debouncer, `btn_pe` and `btn_ne`, and classifies each gesture. The recognised gestures are:

- a single click,
- a double click,
- a long press, followed by auto-repeat for as long as the button stays held.

The block sits between each front-panel button conditioner and the fan control FSMs (speed step, timer set, mode), so those FSMs act on gestures rather than on raw edges. All outputs are registered one-cycle pulses, except `held`, which is a level.

## Interface

Parameters:
- TICK_DIV, 100_000: clk cycles per 1 ms tick (100 MHz clock); must be ≥1.
- LONG_MS, 1000: hold time in ms before `long_press` fires; must be ≥1.
- DCLICK_MS, 300: window in ms after a release in which a second press makes a double click; must be ≥1.
- REPEAT_MS, 200: spacing in ms between `repeat` pulses while the long press is held; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset_p  in  1  reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- btn_pe  in  1  one-cycle pulse: button pressed (debounced).
- btn_ne  in  1  one-cycle pulse: button released (debounced).
- short_click  out  1  pulse: single click confirmed.
- double_click  out  1  pulse: second release inside the window.
- long_press  out  1  pulse: hold reached LONG_MS.
- repeat  out  1  pulse every REPEAT_MS while held after `long_press`.
- held  out  1  level: button currently down, as tracked by the FSM.

## Operation

**States:** IDLE, PRESSED, WAIT_SECOND, SECOND_PRESSED, LONG_HELD.

**Time base:**
- The ms prescaler counts 0..TICK_DIV-1 and produces a 1 ms tick.
- The ms counter increments on each tick.
- Both counters clear on every state transition, including a LONG_HELD repeat restart.
- "Timeout X" means the ms counter has reached X.

**Transitions:**
- IDLE:
  - btn_pe → PRESSED.
  - btn_ne is ignored.
- PRESSED:
  - btn_ne → WAIT_SECOND.
  - Timeout LONG_MS → `long_press`, then LONG_HELD.
- WAIT_SECOND:
  - btn_pe → SECOND_PRESSED.
  - Timeout DCLICK_MS → `short_click`, then IDLE.
  - Timeout and btn_pe in the same cycle → `short_click`, then PRESSED. The timeout wins, and the new press is not lost.
- SECOND_PRESSED:
  - btn_ne → `double_click`, then IDLE.
  - Timeout LONG_MS → `long_press`, then LONG_HELD. The double click is abandoned and no `short_click` is issued.
- LONG_HELD:
  - Timeout REPEAT_MS → `repeat`; stay in LONG_HELD with counters cleared.
  - btn_ne → IDLE, with no further pulse.
  - btn_ne coinciding with a repeat timeout → IDLE, and no `repeat` is issued.

**Input edge cases:**
- btn_pe and btn_ne asserted in the same cycle are treated as a glitch: both are ignored in every state.
- btn_pe is ignored in PRESSED, SECOND_PRESSED and LONG_HELD.
- btn_ne is ignored in WAIT_SECOND.

**Outputs:**
- At most one pulse output is high in any cycle.
- `held` = 1 exactly in PRESSED, SECOND_PRESSED and LONG_HELD.

**Reset:**
- All outputs are 0, the state is IDLE and both counters are 0 in the cycle after reset_p is sampled high.
- Reset mid-gesture discards the gesture. A btn_ne arriving after reset is ignored.

**Widths:**
- Prescaler: $clog2(TICK_DIV) bits, minimum 1.
- ms counter: $clog2(max(LONG_MS, DCLICK_MS, REPEAT_MS)+1) bits.
- Counters never wrap: every state that counts exits or clears at its threshold.

## Timing

- Input pulse at cycle T: the new state is visible at T+1, and its counters start from 0 at T+1.
- A timeout of X ms in a state entered at cycle S is detected at cycle S + X·TICK_DIV − 1. The output pulse and next state are visible one cycle later, at S + X·TICK_DIV.
- Latencies relative to the input pulse:
  - `long_press`: btn_pe at T → pulse at T + LONG_MS·TICK_DIV + 1.
  - `short_click`: btn_ne at T → pulse at T + DCLICK_MS·TICK_DIV + 1.
  - `double_click`: second btn_ne at T → pulse at T+1.
- `repeat` pulses are spaced exactly REPEAT_MS·TICK_DIV cycles apart. The first comes REPEAT_MS·TICK_DIV cycles after `long_press`.

## Structure

- Shared package `button_pkg`: state encoding constants (3-bit) and the gesture pulse ordering. The fan FSMs import it.
- Sub-module `ms_tick_gen`, parameter TICK_DIV:
  - prescaler with synchronous clear;
  - one-cycle `tick` output.
- The FSM, ms counter and output registers live in the top module.

## Test plan

All scenarios use TICK_DIV=4, LONG_MS=10, DCLICK_MS=5, REPEAT_MS=3, with cycles counted from the first btn_pe at cycle 0.

- **Short click:** btn_pe@0, btn_ne@8 → `short_click`@29 only; `held` high 1..8.
- **Long press with repeat:** btn_pe@0, btn_ne@70 → `long_press`@41, `repeat`@53 and @65; `held` low from 71; no other pulses.
- **Double click:** btn_pe@0, btn_ne@8, btn_pe@15, btn_ne@20 → `double_click`@21; no `short_click`.
- **Window boundary:**
  - btn_pe@0, btn_ne@8, btn_pe@28 → `short_click`@29 and state PRESSED; then btn_ne@35 → `short_click`@56.
  - Same with the second btn_pe@29 → `short_click`@29 and state PRESSED.
- **Glitch and reset:**
  - btn_pe and btn_ne together@0 → no state change.
  - btn_pe@2, reset_p@30 → all outputs 0 at 31; btn_ne@35 ignored; no pulses ever.
- **Second press held long:** btn_pe@0, btn_ne@8, btn_pe@15 held → `long_press`@56, `repeat`@68; no `double_click`.
